// File: rtl/ddr4_dimm_responder_if.sv
// Command and response bundle between the controller scheduler and the DIMM-side model.
interface ddr4_dimm_responder_if;
  // Handshake: cmd_valid qualifies every cmd_* field in the cycle it is high.
  // There is no ready; each valid command is consumed at the edge that samples it.
  // rd_valid, wr_ack and err_valid are single-cycle pulses with no acknowledge.
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [13:0] cmd_row;
  logic [10:0] cmd_col;
  logic        rd_valid;
  logic [3:0]  rd_bank;
  logic [13:0] rd_row;
  logic [10:0] rd_col;
  logic        wr_ack;
  logic [3:0]  wr_bank;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] bank_open;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] bank_state;  // debug view, 2 bits per bank: 0 idle, 1 activating, 2 active, 3 precharging

  modport master (
    output cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  rd_valid, rd_bank, rd_row, rd_col, wr_ack, wr_bank,
    input  err_valid, err_code, bank_open, rd_count, wr_count, bank_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output rd_valid, rd_bank, rd_row, rd_col, wr_ack, wr_bank,
    output err_valid, err_code, bank_open, rd_count, wr_count, bank_state
  );
endinterface

// File: rtl/ddr4_dimm_responder.sv
// DDR4 device-side responder: per-bank row state and timing for 16 banks, fixed-latency
// read/write completions, and registered reporting of timing and protocol violations.
module ddr4_dimm_responder #(
  parameter int T_RCD = 24,
  parameter int T_RAS = 52,
  parameter int T_RP  = 24,
  parameter int T_CL  = 24,
  parameter int T_CWD = 20
) (
  input logic                  clk,
  input logic                  rst,
  ddr4_dimm_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } bank_state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  bank;
    logic [13:0] row;
    logic [10:0] col;
  } rd_slot_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] bank;
  } wr_slot_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;

  localparam logic [2:0] ERR_ACT_BUSY = 3'd1;
  localparam logic [2:0] ERR_NOT_OPEN = 3'd2;
  localparam logic [2:0] ERR_EARLY_PRE = 3'd3;
  localparam logic [2:0] ERR_BAD_OP   = 3'd4;

  localparam logic [6:0] RCD_C = 7'(T_RCD);
  localparam logic [6:0] RAS_C = 7'(T_RAS);
  localparam logic [6:0] RP_C  = 7'(T_RP);

  bank_state_t state_q [16];
  bank_state_t state_d [16];
  logic [6:0]  timer_q [16];
  logic [6:0]  timer_d [16];
  logic [13:0] row_q   [16];
  logic [13:0] row_d   [16];

  logic [3:0]  bank;
  bank_state_t cur_state;
  logic [6:0]  cur_timer;

  logic        act_ok;
  logic        pre_ok;
  logic        rd_ok;
  logic        wr_ok;
  logic        cmd_err;
  logic [2:0]  cmd_err_code;

  assign bank      = {bus.cmd_bg, bus.cmd_ba};
  assign cur_state = state_q[bank];
  assign cur_timer = timer_q[bank];

  always_comb begin : decode
    act_ok       = 1'b0;
    pre_ok       = 1'b0;
    rd_ok        = 1'b0;
    wr_ok        = 1'b0;
    cmd_err      = 1'b0;
    cmd_err_code = 3'd0;
    if (bus.cmd_valid) begin
      case (bus.cmd_op)
        OP_NOP: ;
        OP_ACT: begin
          if (cur_state == IDLE) act_ok = 1'b1;
          else begin
            cmd_err      = 1'b1;
            cmd_err_code = ERR_ACT_BUSY;
          end
        end
        OP_RD, OP_WR: begin
          if (cur_state == ACTIVE) begin
            rd_ok = (bus.cmd_op == OP_RD);
            wr_ok = (bus.cmd_op == OP_WR);
          end else begin
            cmd_err      = 1'b1;
            cmd_err_code = ERR_NOT_OPEN;
          end
        end
        OP_PRE: begin
          // PRE to an idle or already-precharging bank is a silent no-op.
          if ((cur_state == ACTIVATING) || (cur_state == ACTIVE)) begin
            if (cur_timer >= RAS_C) pre_ok = 1'b1;
            else begin
              cmd_err      = 1'b1;
              cmd_err_code = ERR_EARLY_PRE;
            end
          end
        end
        default: begin
          cmd_err      = 1'b1;
          cmd_err_code = ERR_BAD_OP;
        end
      endcase
    end
  end

  // The timer is loaded with 1 by the accepting edge, so timer >= N at edge T+N
  // means N cycles have elapsed since the ACT/PRE.
  always_comb begin : bank_next
    for (int i = 0; i < 16; i++) begin
      state_d[i] = state_q[i];
      row_d[i]   = row_q[i];
      timer_d[i] = (timer_q[i] == 7'd127) ? timer_q[i] : timer_q[i] + 7'd1;
      case (state_q[i])
        ACTIVATING:  if (timer_d[i] >= RCD_C) state_d[i] = ACTIVE;
        PRECHARGING: if (timer_d[i] >= RP_C)  state_d[i] = IDLE;
        default: ;
      endcase
      if (4'(i) == bank) begin
        if (act_ok) begin
          state_d[i] = (RCD_C <= 7'd1) ? ACTIVE : ACTIVATING;
          timer_d[i] = 7'd1;
          row_d[i]   = bus.cmd_row;
        end
        if (pre_ok) begin
          state_d[i] = (RP_C <= 7'd1) ? IDLE : PRECHARGING;
          timer_d[i] = 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin : bank_regs
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= 7'd0;
        row_q[i]   <= 14'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        row_q[i]   <= row_d[i];
      end
    end
  end

  rd_slot_t rd_in;
  wr_slot_t wr_in;
  rd_slot_t rd_pipe [T_CL];
  wr_slot_t wr_pipe [T_CWD];
  rd_slot_t rd_out;
  wr_slot_t wr_out;

  always_comb begin : pipe_entry
    rd_in = '0;
    wr_in = '0;
    if (rd_ok) begin
      rd_in.valid = 1'b1;
      rd_in.bank  = bank;
      rd_in.row   = row_q[bank];
      rd_in.col   = bus.cmd_col;
    end
    if (wr_ok) begin
      wr_in.valid = 1'b1;
      wr_in.bank  = bank;
    end
  end

  // Stage k holds a command k edges after acceptance; the output register adds the last edge.
  always_ff @(posedge clk) begin : return_pipes
    if (rst) begin
      for (int i = 0; i < T_CL; i++)  rd_pipe[i] <= '0;
      for (int i = 0; i < T_CWD; i++) wr_pipe[i] <= '0;
      rd_out <= '0;
      wr_out <= '0;
    end else begin
      rd_pipe[0] <= rd_in;
      for (int i = 1; i < T_CL; i++)  rd_pipe[i] <= rd_pipe[i-1];
      wr_pipe[0] <= wr_in;
      for (int i = 1; i < T_CWD; i++) wr_pipe[i] <= wr_pipe[i-1];
      rd_out <= rd_pipe[T_CL-1];
      wr_out <= wr_pipe[T_CWD-1];
    end
  end

  logic        err_stage_valid;
  logic [2:0]  err_stage_code;
  logic        err_valid_q;
  logic [2:0]  err_code_q;
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk) begin : err_and_counters
    if (rst) begin
      err_stage_valid <= 1'b0;
      err_stage_code  <= 3'd0;
      err_valid_q     <= 1'b0;
      err_code_q      <= 3'd0;
      rd_count_q      <= 32'd0;
      wr_count_q      <= 32'd0;
    end else begin
      err_stage_valid <= cmd_err;
      err_stage_code  <= cmd_err_code;
      err_valid_q     <= err_stage_valid;
      if (err_stage_valid) err_code_q <= err_stage_code;
      if (rd_ok) rd_count_q <= rd_count_q + 32'd1;
      if (wr_ok) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  logic [15:0] bank_open_w;
  logic [31:0] bank_state_w;

  always_comb begin : bank_view
    bank_open_w  = '0;
    bank_state_w = '0;
    for (int i = 0; i < 16; i++) begin
      bank_open_w[i]         = (state_q[i] == ACTIVATING) || (state_q[i] == ACTIVE);
      bank_state_w[2*i +: 2] = state_q[i];
    end
  end

  assign bus.rd_valid   = rd_out.valid;
  assign bus.rd_bank    = rd_out.bank;
  assign bus.rd_row     = rd_out.row;
  assign bus.rd_col     = rd_out.col;
  assign bus.wr_ack     = wr_out.valid;
  assign bus.wr_bank    = wr_out.bank;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.bank_open  = bank_open_w;
  assign bus.rd_count   = rd_count_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.bank_state = bank_state_w;
endmodule

// File: tb/tb_ddr4_dimm_responder.sv
// Bench for ddr4_dimm_responder: directed timing scenarios plus randomized traffic
// checked every cycle against an edge-timestamp model of the DIMM.
module tb_ddr4_dimm_responder;
  localparam int T_RCD = 24;
  localparam int T_RAS = 52;
  localparam int T_RP  = 24;
  localparam int T_CL  = 24;
  localparam int T_CWD = 20;
  localparam int NEVER = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ddr4_dimm_responder_if bus ();

  ddr4_dimm_responder #(
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_CL(T_CL), .T_CWD(T_CWD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Bank status is derived from the edge numbers of the last accepted ACT and PRE.
  int          act_edge [16];
  int          pre_edge [16];
  logic [13:0] open_row [16];
  logic [31:0] m_rd_cnt;
  logic [31:0] m_wr_cnt;
  logic [2:0]  m_err_code;
  logic [60:0] exp_rd_q[$];   // {due edge, bank, row, col}
  logic [35:0] exp_wr_q[$];   // {due edge, bank}
  logic [34:0] exp_err_q[$];  // {due edge, code}

  function automatic void model_clear();
    for (int b = 0; b < 16; b++) begin
      act_edge[b] = NEVER;
      pre_edge[b] = NEVER;
      open_row[b] = 14'd0;
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_err_q.delete();
    m_rd_cnt   = 32'd0;
    m_wr_cnt   = 32'd0;
    m_err_code = 3'd0;
  endfunction

  // 0 idle, 1 opening, 2 open, 3 closing -- as seen by a command at edge e
  function automatic int phase(int b, int e);
    if (act_edge[b] > pre_edge[b]) return (e - act_edge[b] >= T_RCD) ? 2 : 1;
    if (e - pre_edge[b] < T_RP) return 3;
    return 0;
  endfunction

  function automatic void model_cmd(int op, int b, logic [13:0] row, logic [10:0] col, int e);
    int ph;
    int code;
    ph   = phase(b, e);
    code = 0;
    case (op)
      0: ;
      1: if (ph == 0) begin act_edge[b] = e; open_row[b] = row; end else code = 1;
      2: if (ph == 2) begin
           exp_rd_q.push_back({32'(e + T_CL), 4'(b), open_row[b], col});
           m_rd_cnt = m_rd_cnt + 32'd1;
         end else code = 2;
      3: if (ph == 2) begin
           exp_wr_q.push_back({32'(e + T_CWD), 4'(b)});
           m_wr_cnt = m_wr_cnt + 32'd1;
         end else code = 2;
      4: if (ph == 1 || ph == 2) begin
           if (e - act_edge[b] >= T_RAS) pre_edge[b] = e; else code = 3;
         end
      default: code = 4;
    endcase
    if (code != 0) exp_err_q.push_back({32'(e + 1), 3'(code)});
  endfunction

  // ---------------- scoreboard monitor ----------------
  bit          rd_hit, wr_hit, er_hit;
  logic [60:0] rd_e;
  logic [35:0] wr_e;
  logic [34:0] er_e;
  logic [15:0] exp_open;

  always @(negedge clk) begin
    if (mon_en) begin
      rd_hit = 1'b0; wr_hit = 1'b0; er_hit = 1'b0;
      if (exp_rd_q.size() > 0) begin rd_e = exp_rd_q[0]; rd_hit = (rd_e[60:29] == 32'(cyc)); end
      if (exp_wr_q.size() > 0) begin wr_e = exp_wr_q[0]; wr_hit = (wr_e[35:4] == 32'(cyc)); end
      if (exp_err_q.size() > 0) begin er_e = exp_err_q[0]; er_hit = (er_e[34:3] == 32'(cyc)); end
      if (rd_hit) void'(exp_rd_q.pop_front());
      if (wr_hit) void'(exp_wr_q.pop_front());
      if (er_hit) begin void'(exp_err_q.pop_front()); m_err_code = er_e[2:0]; end

      n_cmp++;
      if (bus.rd_valid !== rd_hit) begin
        n_bad++; $display("FAIL mon_rd_valid cyc=%0d: got %b expected %b", cyc, bus.rd_valid, rd_hit);
      end
      if (rd_hit) begin
        n_cmp++;
        if ({bus.rd_bank, bus.rd_row, bus.rd_col} !== rd_e[28:0]) begin
          n_bad++; $display("FAIL mon_rd_fields cyc=%0d: got %h/%h/%h expected %h/%h/%h", cyc,
                            bus.rd_bank, bus.rd_row, bus.rd_col, rd_e[28:25], rd_e[24:11], rd_e[10:0]);
        end
      end
      n_cmp++;
      if (bus.wr_ack !== wr_hit) begin
        n_bad++; $display("FAIL mon_wr_ack cyc=%0d: got %b expected %b", cyc, bus.wr_ack, wr_hit);
      end
      if (wr_hit) begin
        n_cmp++;
        if (bus.wr_bank !== wr_e[3:0]) begin
          n_bad++; $display("FAIL mon_wr_bank cyc=%0d: got %0d expected %0d", cyc, bus.wr_bank, wr_e[3:0]);
        end
      end
      n_cmp++;
      if (bus.err_valid !== er_hit || bus.err_code !== m_err_code) begin
        n_bad++; $display("FAIL mon_err cyc=%0d: got %b/%0d expected %b/%0d", cyc,
                          bus.err_valid, bus.err_code, er_hit, m_err_code);
      end
      for (int b = 0; b < 16; b++) exp_open[b] = (act_edge[b] > pre_edge[b]);
      n_cmp++;
      if (bus.bank_open !== exp_open) begin
        n_bad++; $display("FAIL mon_bank_open cyc=%0d: got %h expected %h", cyc, bus.bank_open, exp_open);
      end
      n_cmp++;
      if (bus.rd_count !== m_rd_cnt || bus.wr_count !== m_wr_cnt) begin
        n_bad++; $display("FAIL mon_counts cyc=%0d: got %0d/%0d expected %0d/%0d", cyc,
                          bus.rd_count, bus.wr_count, m_rd_cnt, m_wr_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_slot(bit v, int op, int b, logic [13:0] row, logic [10:0] col);
    @(negedge clk);
    #1;
    bus.cmd_valid = v;
    bus.cmd_op    = 3'(op);
    bus.cmd_bg    = 2'(b >> 2);
    bus.cmd_ba    = 2'(b);
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    if (v && !rst) model_cmd(op, b, row, col, cyc + 1);
  endtask

  task automatic nop(int n);
    repeat (n) drive_slot(1'b0, 0, 0, 14'd0, 11'd0);
  endtask

  task automatic issue_at(int e, int op, int b, logic [13:0] row, logic [10:0] col);
    while (cyc + 2 < e) nop(1);
    n_cmp++;
    if (cyc + 2 != e) begin
      n_bad++; $display("FAIL schedule: got edge %0d expected edge %0d", cyc + 2, e);
    end
    drive_slot(1'b1, op, b, row, col);
  endtask

  task automatic wait_until(int e);
    while (cyc < e) nop(1);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    model_clear();
    repeat (n) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2);
    n_cmp++;
    if ({bus.rd_valid, bus.wr_ack, bus.err_valid, bus.err_code} !== 6'd0) begin
      n_bad++; $display("FAIL reset_pulses: got %b%b%b/%0d expected 0", bus.rd_valid, bus.wr_ack, bus.err_valid, bus.err_code);
    end
    n_cmp++;
    if (bus.bank_open !== 16'd0) begin
      n_bad++; $display("FAIL reset_bank_open: got %h expected 0", bus.bank_open);
    end
    n_cmp++;
    if (bus.rd_count !== 32'd0 || bus.wr_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.rd_count, bus.wr_count);
    end
  endtask

  task automatic test_read_path();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 1, 5, 14'h1A2B, 11'd0);
    issue_at(base + 24, 2, 5, 14'd0, 11'h155);
    wait_until(base + 47);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL read_early: got %b expected 0", bus.rd_valid); end
    wait_until(base + 48);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_bank !== 4'd5 || bus.rd_row !== 14'h1A2B || bus.rd_col !== 11'h155) begin
      n_bad++; $display("FAIL read_return: got %b/%0d/%h/%h expected 1/5/1a2b/155",
                        bus.rd_valid, bus.rd_bank, bus.rd_row, bus.rd_col);
    end
    n_cmp++;
    if (bus.rd_count !== 32'd1 || bus.err_code !== 3'd0) begin
      n_bad++; $display("FAIL read_count: got %0d/%0d expected 1/0", bus.rd_count, bus.err_code);
    end
    wait_until(base + 49);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL read_width: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_early_rd();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 1, 0, 14'h0333, 11'd0);
    issue_at(base + 23, 2, 0, 14'd0, 11'h011);
    issue_at(base + 24, 2, 0, 14'd0, 11'h022);
    wait_until(base + 24);
    n_cmp++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 3'd2 || bus.rd_count !== 32'd1) begin
      n_bad++; $display("FAIL early_rd_err: got %b/%0d/%0d expected 1/2/1", bus.err_valid, bus.err_code, bus.rd_count);
    end
    wait_until(base + 47);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL early_rd_ghost: got %b expected 0", bus.rd_valid); end
    wait_until(base + 48);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_col !== 11'h022) begin
      n_bad++; $display("FAIL early_rd_legal: got %b/%h expected 1/022", bus.rd_valid, bus.rd_col);
    end
  endtask

  task automatic test_pre_timing();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 1, 3, 14'(($urandom)), 11'd0);
    issue_at(base + 51, 4, 3, 14'd0, 11'd0);
    issue_at(base + 52, 4, 3, 14'd0, 11'd0);
    wait_until(base + 52);
    n_cmp++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 3'd3 || bus.bank_open[3] !== 1'b0) begin
      n_bad++; $display("FAIL pre_tras: got %b/%0d/%b expected 1/3/0", bus.err_valid, bus.err_code, bus.bank_open[3]);
    end
    issue_at(base + 75, 1, 3, 14'h0001, 11'd0);
    issue_at(base + 76, 1, 3, 14'h0002, 11'd0);
    wait_until(base + 76);
    n_cmp++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 3'd1 || bus.bank_open[3] !== 1'b1) begin
      n_bad++; $display("FAIL act_trp: got %b/%0d/%b expected 1/1/1", bus.err_valid, bus.err_code, bus.bank_open[3]);
    end
    wait_until(base + 77);
    n_cmp++;
    if (bus.err_valid !== 1'b0 || bus.err_code !== 3'd1) begin
      n_bad++; $display("FAIL err_hold: got %b/%0d expected 0/1", bus.err_valid, bus.err_code);
    end
  endtask

  task automatic test_wr_rd();
    int base, t;
    do_reset(2);
    base = cyc + 3;
    t = base + 24;
    issue_at(base, 1, 15, 14'h3FFF, 11'd0);
    issue_at(t, 3, 15, 14'd0, 11'(($urandom)));
    issue_at(t + 4, 2, 15, 14'd0, 11'h7FF);
    wait_until(t + 20);
    n_cmp++;
    if (bus.wr_ack !== 1'b1 || bus.wr_bank !== 4'd15) begin
      n_bad++; $display("FAIL wr_ack: got %b/%0d expected 1/15", bus.wr_ack, bus.wr_bank);
    end
    wait_until(t + 28);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_bank !== 4'd15 || bus.rd_row !== 14'h3FFF) begin
      n_bad++; $display("FAIL wr_rd_read: got %b/%0d/%h expected 1/15/3fff", bus.rd_valid, bus.rd_bank, bus.rd_row);
    end
    n_cmp++;
    if (bus.rd_count !== 32'd1 || bus.wr_count !== 32'd1) begin
      n_bad++; $display("FAIL wr_rd_counts: got %0d/%0d expected 1/1", bus.rd_count, bus.wr_count);
    end
  endtask

  task automatic test_illegal_op();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 6, 7, 14'd0, 11'd0);
    issue_at(base + 2, 4, 2, 14'd0, 11'd0);
    wait_until(base + 1);
    n_cmp++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 3'd4 || bus.bank_open !== 16'd0) begin
      n_bad++; $display("FAIL illegal_op: got %b/%0d/%h expected 1/4/0", bus.err_valid, bus.err_code, bus.bank_open);
    end
    wait_until(base + 3);
    n_cmp++;
    if (bus.err_valid !== 1'b0 || bus.err_code !== 3'd4) begin
      n_bad++; $display("FAIL pre_idle: got %b/%0d expected 0/4", bus.err_valid, bus.err_code);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 1, 9, 14'h0ABC, 11'd0);
    for (int k = 0; k < 3; k++) issue_at(base + 24 + k, 2, 9, 14'd0, 11'(16 * k + 1));
    issue_at(base + 28, 3, 9, 14'd0, 11'd0);
    for (int k = 0; k < 3; k++) begin
      wait_until(base + 48 + k);
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_col !== 11'(16 * k + 1)) begin
        n_bad++; $display("FAIL b2b_rd%0d: got %b/%h expected 1/%h", k, bus.rd_valid, bus.rd_col, 11'(16 * k + 1));
      end
      n_cmp++;
      if (bus.wr_ack !== (k == 0)) begin
        n_bad++; $display("FAIL b2b_wr%0d: got %b expected %b", k, bus.wr_ack, (k == 0));
      end
    end
    wait_until(base + 51);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_reset_in_flight();
    int base;
    do_reset(2);
    base = cyc + 3;
    issue_at(base, 1, 1, 14'h0444, 11'd0);
    issue_at(base + 24, 2, 1, 14'd0, 11'h001);
    issue_at(base + 25, 2, 1, 14'd0, 11'h002);
    wait_until(base + 29);
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      nop(1);
      n_cmp++;
      if (bus.rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_rd cyc=%0d: got %b expected 0", cyc, bus.rd_valid);
      end
    end
    n_cmp++;
    if (bus.rd_count !== 32'd0 || bus.wr_count !== 32'd0 || bus.bank_open !== 16'd0) begin
      n_bad++; $display("FAIL flush_state: got %0d/%0d/%h expected 0/0/0", bus.rd_count, bus.wr_count, bus.bank_open);
    end
  endtask

  task automatic test_random();
    int r, op, b;
    do_reset(2);
    for (int s = 0; s < 4000; s++) begin
      if (s == 2000) do_reset(3);
      r  = $urandom_range(0, 99);
      b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      op = (r < 25) ? 0 : (r < 45) ? 1 : (r < 65) ? 2 : (r < 80) ? 3 : (r < 96) ? 4 : $urandom_range(5, 7);
      drive_slot((r >= 10), op, b, 14'($urandom), 11'($urandom));
    end
    nop(T_CL + 10);
    n_cmp++;
    if (bus.rd_count !== m_rd_cnt || bus.wr_count !== m_wr_cnt) begin
      n_bad++; $display("FAIL random_totals: got %0d/%0d expected %0d/%0d", bus.rd_count, bus.wr_count, m_rd_cnt, m_wr_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_bg    = 2'd0;
    bus.cmd_ba    = 2'd0;
    bus.cmd_row   = 14'd0;
    bus.cmd_col   = 11'd0;
    model_clear();
    do_reset(3);
    mon_en = 1'b1;
    test_reset();
    test_read_path();
    test_early_rd();
    test_pre_timing();
    test_wr_rd();
    test_illegal_op();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
